sipo_piso_master: RTL and testbench
===================================

# sipo_piso_master

Upstream driver for the `sipo_piso` serial register slave. It accepts parallel register write and read requests on a valid/ready port and serialises each one into a strobe-delimited 13-bit frame on `strobe`/`wr_en`/`din`. For reads it captures the slave's `dout` bits and returns the register value on a valid/ready response port. It sits between the on-chip controller (or scan/JTAG bridge) and the slave's serial configuration pins.

## Interface
Parameters:
- `ADDR_WIDTH`, default `` `ADDR_WIDTH `` (5): register address bits.
- `REG_WIDTH`, default `` `REG_WIDTH `` (8): register data bits.
- `MEM_DEPTH`, default `` `MEM_DEPTH `` (16): highest valid address. Valid addresses are 0..MEM_DEPTH.
- `GAP_CYCLES`, default 5, minimum 1: idle cycles with `wr_en` stable before each strobe.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the block can accept a request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_WIDTH: register address.
- `req_wdata` in REG_WIDTH: write data.
- `rsp_valid` out 1: a response is presented.
- `rsp_ready` in 1: the consumer accepts the response.
- `rsp_rdata` out REG_WIDTH: read data. 0 for writes.
- `rsp_err` out 1: the request address was out of range.
- `busy` out 1: the block is not in IDLE.
- `strobe` out 1: frame start pulse to the slave.
- `wr_en` out 1: frame direction to the slave.
- `din` out 1: serial data to the slave.
- `dout` in 1: serial read data from the slave.

## Operation
- Frame length is F = ADDR_WIDTH + REG_WIDTH = 13 bit slots, each one clock long. The frame follows a one-cycle `strobe` pulse.
- Write frame:
  - `wr_en`=1 for the whole frame.
  - Slots 0..7 carry `req_wdata[0..7]`, LSB first.
  - Slots 8..12 carry `req_addr[0..4]`, LSB first.
- Read frame:
  - `wr_en`=0 for the whole frame.
  - Slots 0..4 carry `req_addr[0..4]`, LSB first.
  - Slots 5..12 drive `din`=0. `dout` is sampled at the rising edge ending each of these slots into `rdata[0..7]`, LSB first.
- State machine and transitions:
  - IDLE → GAP on a handshake, when `req_addr` ≤ MEM_DEPTH.
  - IDLE → RESP on a handshake, when `req_addr` > MEM_DEPTH. No frame is sent, `rsp_err`=1 and `rsp_rdata`=0.
  - GAP: lasts GAP_CYCLES cycles, then goes to STROBE.
  - STROBE: lasts 1 cycle, then goes to SHIFT.
  - SHIFT: lasts F cycles, then goes to RESP.
  - RESP → IDLE on `rsp_valid && rsp_ready`.
- Register and output rules:
  - Request fields are latched at the handshake. Later changes on the request inputs have no effect.
  - `wr_en` is set at entry to GAP and holds through the end of SHIFT. It then keeps its last value until the next frame. It never changes while `strobe` is high or during SHIFT.
  - `req_ready` = (state == IDLE). It is combinational from state only.
  - `rsp_valid`, `rsp_rdata` and `rsp_err` are registered. They hold stable while `rsp_valid && !rsp_ready`.
- Reset behaviour:
  - While `rst` is high, all outputs are 0 and the state is IDLE.
  - Asserting `rst` mid-frame abandons the frame. No response is produced. The slave resynchronises on the next `strobe`.
- A handshake is impossible in RESP because `req_ready`=0. Back-to-back requests therefore cost a full frame each.

## Timing
- Let the request handshake be the edge ending cycle 0 (G = GAP_CYCLES):

| Cycles | Activity |
|---|---|
| 1..G | GAP |
| G+1 | `strobe`=1 |
| G+2..G+14 | slots 0..12 |
| G+15 | `rsp_valid`=1 |

- With the default G=5: `strobe` in cycle 6 and `rsp_valid` in cycle 20.
- The earliest next handshake is the cycle after the response handshake. Minimum request-to-request period is G+16 cycles.
- An out-of-range request gives `rsp_valid` in cycle 1.
- `din`, `strobe` and `wr_en` come directly from flops, so the slave sees glitch-free pins.

## Structure
- Shared package/include (`config.v`): `ADDR_WIDTH`, `REG_WIDTH`, `MEM_DEPTH`, the frame length F, and `localparam` state encodings (IDLE, GAP, STROBE, SHIFT, RESP).
- One sub-module, `sipo_piso_bitcnt`: a loadable down-counter shared by GAP and SHIFT, with a terminal-count flag.
- The shift register and FSM live in the top module.

## Test plan
- Write addr 1 with data 0x41. Slots 0..12 must carry 1,0,0,0,0,0,1,0 then 1,0,0,0,0. `wr_en`=1 and `strobe` is in cycle 6. `rsp_valid` is in cycle 20 with `rsp_err`=0.
- Read addr 3, with a slave model returning 0xBA on slots 5..12. Slots 0..4 must carry 1,1,0,0,0 and `wr_en`=0. The response must be `rsp_rdata`=0xBA.
- Write then read back all 17 addresses through a behavioural `sipo_piso`, writing values 0x0D, 0x41, … and random data. Every readback must match.
- Read addr 20. The response must come in cycle 1 with `rsp_err`=1 and `rsp_rdata`=0. `strobe` must never pulse.
- Hold `rsp_ready`=0 for 10 cycles. The response must stay stable and `req_ready` must stay 0. A `req_valid` during the stall must not be accepted.
- Assert `rst` in slot 6 of a write frame. All outputs must go to 0 immediately and no response is produced. A following read must complete correctly.

Source files
------------

// File: rtl/sipo_piso_master_pkg.sv
// sipo_piso_master_pkg
//   Shared definitions for the sipo_piso serial master: default geometry of
//   the slave register file, FSM state encoding and a counter width helper.
package sipo_piso_master_pkg;

  localparam int DEF_ADDR_WIDTH = 5;   // register address bits
  localparam int DEF_REG_WIDTH  = 8;   // register data bits
  localparam int DEF_MEM_DEPTH  = 16;  // highest valid address
  localparam int DEF_GAP_CYCLES = 5;   // idle cycles before each strobe

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GAP    = 3'd1,
    ST_STROBE = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sipo_piso_bitcnt.sv
// sipo_piso_bitcnt
//   Loadable down-counter shared by the GAP and SHIFT phases of the master.
//   Ports:
//     clk, rst      : clock, asynchronous active-high reset
//     load          : load load_val (takes priority over dec)
//     load_val [W]  : value to load
//     dec           : decrement by one, saturating at zero
//     cnt  [W]      : current count
//     tc            : terminal count, high while cnt == 0
module sipo_piso_bitcnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == '0);

endmodule

// File: rtl/sipo_piso_master.sv
// sipo_piso_master
//   Serialises parallel register write/read requests into strobe-delimited
//   frames for the sipo_piso slave and returns read data / range errors on a
//   valid/ready response port.
//   Ports:
//     clk, rst                      : clock, asynchronous active-high reset
//     req_valid/req_ready           : request handshake
//     req_we, req_addr, req_wdata   : request fields (1 = write)
//     rsp_valid/rsp_ready           : response handshake
//     rsp_rdata, rsp_err            : read data (0 for writes), range error
//     busy                          : not idle
//     strobe, wr_en, din            : serial pins to the slave (all flopped)
//     dout                          : serial read data from the slave
module sipo_piso_master
  import sipo_piso_master_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [REG_WIDTH-1:0]  req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [REG_WIDTH-1:0]  rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  strobe,
  output logic                  wr_en,
  output logic                  din,
  input  logic                  dout
);

  localparam int F       = ADDR_WIDTH + REG_WIDTH;
  localparam int CNT_MAX = (GAP_CYCLES > F) ? GAP_CYCLES : F;
  localparam int CNT_W   = cnt_width(CNT_MAX);

  state_e                 state_q, state_d;
  logic [F-1:0]           sh_q, sh_d;        // outgoing frame, slot 0 in bit 0
  logic [REG_WIDTH-1:0]   cap_q, cap_d;      // incoming read bits
  logic                   wr_en_q, wr_en_d;  // also the latched request direction
  logic                   strobe_q, strobe_d;
  logic                   din_q, din_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [REG_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;

  logic                   hs;
  logic                   addr_ok;
  logic                   cnt_load;
  logic [CNT_W-1:0]       cnt_load_val;
  logic                   cnt_dec;
  logic [CNT_W-1:0]       cnt;
  logic                   cnt_tc;
  logic [REG_WIDTH-1:0]   cap_shift;

  // Ready is withheld while reset is asserted so every output reads 0 then.
  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign hs        = req_valid && req_ready;
  assign addr_ok   = (int'(req_addr) <= MEM_DEPTH);
  // New dout bit enters at the MSB; after REG_WIDTH shifts the first
  // sampled bit has reached bit 0.
  assign cap_shift = {dout, cap_q[REG_WIDTH-1:1]};

  // GAP counts GAP_CYCLES-1 down to 0, SHIFT counts F-1 down to 0, so each
  // phase ends on the cycle the counter reads zero.
  assign cnt_load     = (hs && addr_ok) || (state_q == ST_STROBE);
  assign cnt_load_val = (state_q == ST_STROBE) ? CNT_W'(F - 1) : CNT_W'(GAP_CYCLES - 1);
  assign cnt_dec      = (state_q == ST_GAP) || (state_q == ST_SHIFT);

  sipo_piso_bitcnt #(
    .W (CNT_W)
  ) u_bitcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (hs) state_d = addr_ok ? ST_GAP : ST_RESP;
      ST_GAP:    if (cnt_tc) state_d = ST_STROBE;
      ST_STROBE: state_d = ST_SHIFT;
      ST_SHIFT:  if (cnt_tc) state_d = ST_RESP;
      // rsp_valid is high for the whole of RESP
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; every pin is registered from these.
  always_comb begin
    sh_d        = sh_q;
    cap_d       = cap_q;
    wr_en_d     = wr_en_q;
    strobe_d    = 1'b0;
    din_d       = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hs) begin
          if (addr_ok) begin
            wr_en_d = req_we;
            sh_d    = req_we ? {req_addr, req_wdata}
                             : {{REG_WIDTH{1'b0}}, req_addr};
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      ST_GAP: begin
        strobe_d = cnt_tc;
      end
      ST_STROBE: begin
        // Present slot 0 on din as the strobe drops.
        din_d = sh_q[0];
        sh_d  = sh_q >> 1;
      end
      ST_SHIFT: begin
        if (!cnt_tc) begin
          din_d = sh_q[0];
          sh_d  = sh_q >> 1;
        end
        // The last REG_WIDTH slots of a read frame carry the slave's data.
        if (!wr_en_q && (cnt < CNT_W'(REG_WIDTH))) begin
          cap_d = cap_shift;
        end
        if (cnt_tc) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = wr_en_q ? '0 : cap_shift;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: begin
        sh_d = sh_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q        <= '0;
      cap_q       <= '0;
      wr_en_q     <= 1'b0;
      strobe_q    <= 1'b0;
      din_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      sh_q        <= sh_d;
      cap_q       <= cap_d;
      wr_en_q     <= wr_en_d;
      strobe_q    <= strobe_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign strobe    = strobe_q;
  assign wr_en     = wr_en_q;
  assign din       = din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sipo_piso_master.sv
// tb_sipo_piso_master
//   Drives request sequences into sipo_piso_master, models the sipo_piso
//   slave behaviourally on the serial pins, and checks responses through a
//   scoreboard fed by a reference register array.
module tb_sipo_piso_master;
  import sipo_piso_master_pkg::*;

  localparam int AW = 5;
  localparam int RW = 8;
  localparam int MD = 16;
  localparam int G  = 5;
  localparam int F  = AW + RW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [RW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [RW-1:0] rsp_rdata;
  logic          busy, strobe, wr_en, din;
  logic          dout = 1'b0;

  sipo_piso_master #(
    .ADDR_WIDTH (AW),
    .REG_WIDTH  (RW),
    .MEM_DEPTH  (MD),
    .GAP_CYCLES (G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .strobe    (strobe),
    .wr_en     (wr_en),
    .din       (din),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [RW-1:0] rdata;
    logic          err;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  logic [RW-1:0] ref_mem   [0:MD];
  logic [RW-1:0] slave_mem [0:MD];

  // ---------------- behavioural slave ----------------
  bit            in_frame = 0;
  int            slot = 0;
  logic          fwe;
  logic [F-1:0]  fbits;
  logic [F-1:0]  last_frame = '0;
  logic          last_we = 1'b0;
  int            frame_cnt = 0, strobe_cnt = 0, last_strobe_cyc = -1, wr_en_glitch = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0;
      dout     = 1'b0;
    end else if (strobe) begin
      in_frame        = 1;
      slot            = 0;
      fwe             = wr_en;
      fbits           = '0;
      strobe_cnt++;
      last_strobe_cyc = cyc;
      dout            = 1'b0;
    end else if (in_frame) begin
      if (wr_en !== fwe) wr_en_glitch++;
      fbits[slot] = din;
      if (!fwe && slot >= AW && int'(fbits[AW-1:0]) <= MD)
        dout = slave_mem[fbits[AW-1:0]][slot-AW];
      else
        dout = 1'b0;
      slot++;
      if (slot == F) begin
        in_frame   = 0;
        frame_cnt++;
        last_frame = fbits;
        last_we    = fwe;
        if (fwe && int'(fbits[F-1:RW]) <= MD) slave_mem[fbits[F-1:RW]] = fbits[RW-1:0];
      end
    end else begin
      dout = 1'b0;
    end
  end

  // ---------------- response monitor ----------------
  bit            in_rsp = 0;
  logic [RW-1:0] held_rdata;
  logic          held_err;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (!in_rsp) begin
        in_rsp     = 1;
        held_rdata = rsp_rdata;
        held_err   = rsp_err;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rdata=0x%0h err=%0b, required no response", rsp_rdata, rsp_err);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_rdata", rsp_rdata, mon_e.rdata);
          check("rsp_err", rsp_err, mon_e.err);
          check("rsp_cycle", cyc, mon_e.cyc);
        end
      end else begin
        check("rsp_stable", {rsp_err, rsp_rdata}, {held_err, held_rdata});
        check("ready_in_resp", req_ready, 1'b0);
      end
      if (rsp_ready) in_rsp = 0;
    end
  end

  // Random back-pressure on the response port.
  bit rand_stall = 0;
  always @(posedge clk) begin
    if (rand_stall) begin
      #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called one time unit after a rising edge; returns one unit after the
  // handshake edge with the handshake cycle number in h.
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [RW-1:0] data,
                        output int h);
    exp_t e;
    bit   rdy;
    int   n;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    req_valid = 1'b1;
    n   = 0;
    rdy = 0;
    do begin
      @(negedge clk) rdy = req_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 300);
    #1;
    req_valid = 1'b0;
    h = cyc;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no handshake in %0d cycles, required req_ready", n);
      return;
    end
    // Scramble the request inputs; the latched copy must be used.
    req_we    = $urandom_range(0, 1);
    req_addr  = AW'($urandom);
    req_wdata = RW'($urandom);
    if (int'(addr) > MD) begin
      e.rdata = '0; e.err = 1'b1; e.cyc = h;
    end else if (we) begin
      ref_mem[addr] = data;
      e.rdata = '0; e.err = 1'b0; e.cyc = h + G + 14;
    end else begin
      e.rdata = ref_mem[addr]; e.err = 1'b0; e.cyc = h + G + 14;
    end
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy || in_rsp) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d, required idle", busy, sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by time %0t, required completion", $time);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int h, sc, fc, n;
    logic [RW-1:0] d, old;

    for (int i = 0; i <= MD; i++) begin
      ref_mem[i]   = '0;
      slave_mem[i] = '0;
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_err, busy, strobe, wr_en, din}, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", req_ready, 1'b1);
    check("busy_after_reset", busy, 1'b0);

    // Directed write: addr 1, data 0x41.
    do_req(1'b1, 5'd1, 8'h41, h);
    wait_idle();
    check("wr_frame_bits", last_frame, {5'd1, 8'h41});
    check("wr_frame_wr_en", last_we, 1'b1);
    check("wr_strobe_cycle", last_strobe_cyc, h + G);

    // Directed read: addr 3 with the slave holding 0xBA.
    slave_mem[3] = 8'hBA;
    ref_mem[3]   = 8'hBA;
    do_req(1'b0, 5'd3, 8'h00, h);
    wait_idle();
    check("rd_frame_bits", last_frame, {8'h00, 5'd3});
    check("rd_frame_wr_en", last_we, 1'b0);

    // Write then read back every address, with random response stalls.
    rand_stall = 1;
    for (int a = 0; a <= MD; a++) begin
      d = (a == 0) ? 8'h0D : (a == 1) ? 8'h41 : RW'($urandom);
      do_req(1'b1, AW'(a), d, h);
    end
    for (int a = 0; a <= MD; a++) do_req(1'b0, AW'(a), RW'($urandom), h);
    wait_idle();

    // Out-of-range requests: immediate error, no strobe.
    sc = strobe_cnt;
    do_req(1'b0, 5'd20, 8'h00, h);
    for (int i = 0; i < 4; i++) do_req(1'($urandom_range(0, 1)), AW'($urandom_range(MD + 1, 31)), RW'($urandom), h);
    wait_idle();
    check("oor_no_strobe", strobe_cnt, sc);

    // Response stall with a competing request.
    rand_stall = 0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    fc = frame_cnt;
    do_req(1'b1, 5'd5, 8'h5A, h);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_rsp_seen", rsp_valid, 1'b1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd6; req_wdata = 8'hEE;
    repeat (10) begin
      @(posedge clk); #1;
      check("stall_req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    check("stall_one_frame", frame_cnt, fc + 1);
    check("stall_idle", busy, 1'b0);

    // Reset in slot 6 of a write frame, then read the same address back.
    old = ref_mem[7];
    do_req(1'b1, 5'd7, ~old, h);
    n = 0;
    while (cyc < h + G + 7 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    rst = 1'b1;
    #1;
    check("midframe_reset_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_err, busy, strobe, wr_en, din}, '0);
    sb.delete();
    ref_mem[7] = old;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_req(1'b0, 5'd7, 8'h00, h);
    wait_idle();

    // Random mix of reads, writes and out-of-range addresses.
    rand_stall = 1;
    for (int i = 0; i < 30; i++)
      do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, MD + 3)), RW'($urandom), h);
    wait_idle();
    rand_stall = 0;

    check("wr_en_stable_in_frame", wr_en_glitch, 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
